// File: rtl/io_tile_cfg_array.sv
// io_tile_cfg_array: NUM_PADS GPIO pads behind one configuration-chain segment.
// Configuration bits shift through a shadow chain (ccff_head -> ccff_tail) and
// are committed atomically to the active register once a full frame is in.
// Pad behaviour (direction, in/out registering, inversion) follows only the
// active register, so a partially shifted frame never disturbs the pads.
module io_tile_cfg_array #(
  parameter int NUM_PADS   = 4,
  parameter int CFG_BITS   = 4,
  parameter int TOTAL_BITS = NUM_PADS * CFG_BITS
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  output logic                cfg_done,
  input  logic [NUM_PADS-1:0] io_outpad,
  output logic [NUM_PADS-1:0] io_inpad,
  input  logic [NUM_PADS-1:0] gfpga_pad_in,
  output logic [NUM_PADS-1:0] gfpga_pad_out,
  output logic [NUM_PADS-1:0] gfpga_pad_oe
);

  // Per-pad configuration word layout.
  localparam int BIT_OE   = 0;
  localparam int BIT_INR  = 1;
  localparam int BIT_OUTR = 2;
  localparam int BIT_INV  = 3;

  localparam int CNT_W = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS - 1);

  // Frame-tracking FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] sr_q, sr_d;
  logic [TOTAL_BITS-1:0] act_q, act_d;
  logic [NUM_PADS-1:0]   q_in_q;
  logic [NUM_PADS-1:0]   q_out_q;
  logic [TOTAL_BITS-1:0] sr_shift_s;

  assign sr_shift_s = {sr_q[TOTAL_BITS-2:0], ccff_head};

  // Shadow chain shifts on every enabled cycle, independent of frame state.
  always_comb begin
    sr_d = sr_q;
    if (ccff_en) begin
      sr_d = sr_shift_s;
    end else begin
      sr_d = sr_q;
    end
  end

  // Frame counter / commit FSM: the last bit of a frame commits on its own edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ccff_en) begin
          // The bit shifted on this edge is the first of a new frame.
          cnt_d   = CNT_ONE;
          state_d = ST_SHIFT;
        end else begin
          cnt_d   = cnt_q;
          state_d = state_q;
        end
      end
      ST_SHIFT: begin
        if (ccff_en) begin
          if (cnt_q == CNT_LAST) begin
            act_d   = sr_shift_s;
            cnt_d   = CNT_ZERO;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = ST_SHIFT;
          end
        end else begin
          // Pause: hold position inside the frame.
          cnt_d   = cnt_q;
          state_d = ST_SHIFT;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean idle state.
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, chain, active configuration and pad datapath registers.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      sr_q    <= {TOTAL_BITS{1'b0}};
      act_q   <= {TOTAL_BITS{1'b0}};
      q_in_q  <= {NUM_PADS{1'b0}};
      q_out_q <= {NUM_PADS{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      act_q   <= act_d;
      q_in_q  <= gfpga_pad_in;
      q_out_q <= io_outpad;
    end
  end

  assign ccff_tail = sr_q[TOTAL_BITS-1];
  assign cfg_done  = (state_q == ST_DONE);

  // Per-pad datapath, driven only by the committed configuration.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [CFG_BITS-1:0] cfg_s;
    logic                in_sel_s;
    logic                out_sel_s;

    assign cfg_s     = act_q[CFG_BITS*p +: CFG_BITS];
    assign in_sel_s  = cfg_s[BIT_INR]  ? q_in_q[p]  : gfpga_pad_in[p];
    assign out_sel_s = cfg_s[BIT_OUTR] ? q_out_q[p] : io_outpad[p];

    // The input path stays live for output pads so they read back their own pad.
    assign io_inpad[p]      = in_sel_s ^ cfg_s[BIT_INV];
    assign gfpga_pad_out[p] = cfg_s[BIT_OE] ? (out_sel_s ^ cfg_s[BIT_INV]) : 1'b0;
    assign gfpga_pad_oe[p]  = cfg_s[BIT_OE];
  end

endmodule
